// File: rtl/inst_mem_responder.sv
// Instruction memory with a fixed LATENCY-cycle read pipeline feeding an in-order response FIFO.
// Request-to-rsp_valid is LATENCY cycles; req_ready is a credit check over pipeline plus buffer, so the pipeline never stalls.
module inst_mem_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [XLEN-1:0]              req_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [XLEN-1:0]              rsp_inst,
  output logic                         rsp_err,
  input  logic                         flush,
  input  logic                         load_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]              load_data
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic            vld;
    logic            err;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] mem [MEM_DEPTH];
  logic [XLEN-3:0] word_idx;
  logic            req_err;
  logic            accept;
  logic            push;
  logic            pop;
  entry_t          in_e;
  entry_t          tail;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   count_q;
  logic [CW:0]     occupancy;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [XLEN-1:0] buf_inst [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] buf_err;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Program loading is independent of reset so an image survives a core reset.
  always_ff @(posedge clk) begin
    if (load_we && ({1'b0, load_addr} < (AW + 1)'(MEM_DEPTH))) begin
      mem[load_addr] <= load_data;
    end
  end

  assign word_idx  = req_addr[XLEN-1:2];
  assign req_err   = (req_addr[1:0] != 2'b00) || ({2'b00, word_idx} >= XLEN'(MEM_DEPTH));
  assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};
  assign req_ready = !rst && !flush && (occupancy < (CW + 1)'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;

  always_comb begin
    in_e      = '0;
    in_e.vld  = accept;
    in_e.err  = req_err;
    in_e.inst = req_err ? NOP : mem[word_idx[AW-1:0]];
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign tail = in_e;
    end else begin : g_pipe
      entry_t pipe_q [LATENCY-1];
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          for (int i = 0; i < LATENCY - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= in_e;
          for (int i = 1; i < LATENCY - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign tail = pipe_q[LATENCY-2];
    end
  endgenerate

  assign push = tail.vld;
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q    <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q    <= count_q + CW'(push) - CW'(pop);
      inflight_q <= inflight_q + CW'(accept) - CW'(tail.vld);
    end
  end

  // Credit rule guarantees the write slot never aliases the head being held.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      buf_inst[wr_ptr_q] <= tail.inst;
      buf_err[wr_ptr_q]  <= tail.err;
    end
  end

  assign rsp_valid = !rst && (count_q != '0);
  assign rsp_inst  = rst ? '0 : buf_inst[rd_ptr_q];
  assign rsp_err   = !rst && buf_err[rd_ptr_q];

endmodule
